w5300_sram_ctrl: RTL and testbench

- Byte-wide SRAM-style bus engine: the responder side of the 16-bit W5300 register access handshake (start_ctrl / busy_ctrl / data_rdy_ctrl / writing_finished_signal).
- Each accepted request drives one 8-bit access on the W5300 parallel host bus (CSn/RDn/WRn, 10-bit address, 8-bit data) with parameterised setup/strobe/hold.
- Chains the second byte of a 16-bit access without releasing busy.
- Sits between the 16-bit register interface and top-level pins; the top level owns the tristate buffer.

---
 rtl/w5300_sram_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_w5300_sram_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_sram_ctrl.sv
// w5300_sram_ctrl
//   Byte-wide SRAM-style bus engine for the W5300 parallel host bus.
//   It answers the 16-bit register requester handshake (start_ctrl / busy_ctrl /
//   data_rdy_ctrl / writing_finished_signal). Each accepted request becomes one
//   8-bit access with T_SETUP / T_STROBE / T_HOLD cycle timing. A start_ctrl
//   sampled in GAP chains the next byte without dropping busy_ctrl.
//   The tristate pin buffer lives in the top level; this block only supplies
//   w_data_out / w_data_oe and receives w_data_in.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   start_ctrl, address_in,     request side, sampled in IDLE and GAP
//   operation, data_f2w         (operation 1 = read, 0 = write)
//   busy_ctrl                   high from the cycle after accept until IDLE
//   data_rdy_ctrl               one-cycle pulse, read byte valid on data_w2f
//   writing_finished_signal     active-low one-cycle pulse on write completion
//   data_w2f                    last captured read byte
//   w_addr, w_cs_n, w_rd_n,     W5300 pins
//   w_wr_n, w_data_out,
//   w_data_oe, w_data_in
//
// Optional build macro W5300_SRAM_ACC_CNT_EN adds rd_cnt / wr_cnt outputs,
// counting completed read / write accesses (wrapping 16-bit).
module w5300_sram_ctrl #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_ctrl,
  input  logic [9:0]  address_in,
  input  logic        operation,
  input  logic [7:0]  data_f2w,
  output logic        busy_ctrl,
  output logic        data_rdy_ctrl,
  output logic        writing_finished_signal,
  output logic [7:0]  data_w2f,
  output logic [9:0]  w_addr,
  output logic        w_cs_n,
  output logic        w_rd_n,
  output logic        w_wr_n,
  output logic [7:0]  w_data_out,
  output logic        w_data_oe,
  input  logic [7:0]  w_data_in
`ifdef W5300_SRAM_ACC_CNT_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_GAP
  } state_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] LD_SETUP  = 4'(T_SETUP - 1);
  localparam logic [3:0] LD_STROBE = 4'(T_STROBE - 1);
  localparam logic [3:0] LD_HOLD   = 4'(T_HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [9:0]  w_addr_q, w_addr_d;
  logic [7:0]  w_data_out_q, w_data_out_d;
  logic [7:0]  data_w2f_q, data_w2f_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;
  logic        wfin_q, wfin_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        oe_q, oe_d;
  logic        on_bus;

  // Next state, counter and request latching.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    w_addr_d     = w_addr_q;
    w_data_out_d = w_data_out_q;
    data_w2f_d   = data_w2f_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        if (start_ctrl) begin
          op_d         = operation;
          w_addr_d     = address_in;
          w_data_out_d = data_f2w;
          state_d      = S_SETUP;
          cnt_d        = LD_SETUP;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = LD_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          // Sample the pins on the last strobe-low cycle, before RDn rises.
          if (op_q) data_w2f_d = w_data_in;
          state_d = S_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_GAP;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that each registered output
  // lines up with the state it belongs to.
  always_comb begin
    on_bus = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
    cs_n_d = !on_bus;
    rd_n_d = !((state_d == S_STROBE) && op_d);
    wr_n_d = !((state_d == S_STROBE) && !op_d);
    oe_d   = on_bus && !op_d;
    rdy_d  = (state_d == S_DONE) && op_d;
    wfin_d = !((state_d == S_DONE) && !op_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      op_q         <= 1'b0;
      w_addr_q     <= 10'd0;
      w_data_out_q <= 8'd0;
      data_w2f_q   <= 8'd0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b0;
      wfin_q       <= 1'b1;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      w_addr_q     <= w_addr_d;
      w_data_out_q <= w_data_out_d;
      data_w2f_q   <= data_w2f_d;
      busy_q       <= busy_d;
      rdy_q        <= rdy_d;
      wfin_q       <= wfin_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      oe_q         <= oe_d;
    end
  end

  assign busy_ctrl               = busy_q;
  assign data_rdy_ctrl           = rdy_q;
  assign writing_finished_signal = wfin_q;
  assign data_w2f                = data_w2f_q;
  assign w_addr                  = w_addr_q;
  assign w_cs_n                  = cs_n_q;
  assign w_rd_n                  = rd_n_q;
  assign w_wr_n                  = wr_n_q;
  assign w_data_out              = w_data_out_q;
  assign w_data_oe               = oe_q;

`ifdef W5300_SRAM_ACC_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (state_q == S_DONE) begin
      if (op_q) rd_cnt_d = rd_cnt_q + 16'd1;
      else      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_w5300_sram_ctrl.sv
// Directed bench for w5300_sram_ctrl: a default-timing instance (u_dut) with a
// byte-memory pin model and scoreboard queues, plus a second instance (u_dut2)
// built with T_SETUP=2, T_STROBE=1, T_HOLD=3 for the timing check.
module tb_w5300_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // default-timing instance
  logic       start_ctrl, operation;
  logic [9:0] address_in;
  logic [7:0] data_f2w;
  logic       busy_ctrl, data_rdy_ctrl, writing_finished_signal;
  logic [7:0] data_w2f;
  logic [9:0] w_addr;
  logic       w_cs_n, w_rd_n, w_wr_n, w_data_oe;
  logic [7:0] w_data_out, w_data_in;

  // slow-setup / long-hold instance
  logic       start2, op2;
  logic [9:0] addr2;
  logic [7:0] dout2;
  logic       busy2, rdy2, wfin2;
  logic [7:0] w2f2;
  logic [9:0] w_addr2;
  logic       cs_n2, rd_n2, wr_n2, oe2;
  logic [7:0] wdo2;
  logic [7:0] wdi2;

`ifdef W5300_SRAM_ACC_CNT_EN
  logic [15:0] rd_cnt, wr_cnt, rd_cnt2, wr_cnt2;
`endif

  logic [7:0] mem [0:1023];
  assign w_data_in = mem[w_addr];
  assign wdi2      = 8'h00;

  w5300_sram_ctrl u_dut (
    .clk(clk), .rst(rst),
    .start_ctrl(start_ctrl), .address_in(address_in), .operation(operation),
    .data_f2w(data_f2w), .busy_ctrl(busy_ctrl), .data_rdy_ctrl(data_rdy_ctrl),
    .writing_finished_signal(writing_finished_signal), .data_w2f(data_w2f),
    .w_addr(w_addr), .w_cs_n(w_cs_n), .w_rd_n(w_rd_n), .w_wr_n(w_wr_n),
    .w_data_out(w_data_out), .w_data_oe(w_data_oe), .w_data_in(w_data_in)
`ifdef W5300_SRAM_ACC_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  w5300_sram_ctrl #(.T_SETUP(2), .T_STROBE(1), .T_HOLD(3)) u_dut2 (
    .clk(clk), .rst(rst),
    .start_ctrl(start2), .address_in(addr2), .operation(op2),
    .data_f2w(dout2), .busy_ctrl(busy2), .data_rdy_ctrl(rdy2),
    .writing_finished_signal(wfin2), .data_w2f(w2f2),
    .w_addr(w_addr2), .w_cs_n(cs_n2), .w_rd_n(rd_n2), .w_wr_n(wr_n2),
    .w_data_out(wdo2), .w_data_oe(oe2), .w_data_in(wdi2)
`ifdef W5300_SRAM_ACC_CNT_EN
    , .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected strobe addresses, write bytes and read bytes
  logic [9:0] exp_addr [$];
  logic [7:0] exp_wdata [$];
  logic [7:0] exp_rd [$];
  int rdy_pulses = 0;
  int wf_pulses  = 0;
  logic prev_cs = 1'b1, prev_rd = 1'b1, prev_wr = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      prev_cs <= 1'b1;
      prev_rd <= 1'b1;
      prev_wr <= 1'b1;
    end else begin
      if ((!w_rd_n || !w_wr_n) && prev_rd && prev_wr) begin
        chk("addr_q_nonempty", 32'(exp_addr.size() != 0), 32'd1);
        if (exp_addr.size() != 0) chk("strobe_addr", 32'(w_addr), 32'(exp_addr.pop_front()));
        if (!w_wr_n) begin
          chk("wdata_q_nonempty", 32'(exp_wdata.size() != 0), 32'd1);
          if (exp_wdata.size() != 0) chk("strobe_wdata", 32'(w_data_out), 32'(exp_wdata.pop_front()));
        end
      end
      chk("rd_wr_overlap", 32'(!w_rd_n && !w_wr_n), 32'd0);
      chk("oe_during_read", 32'(w_data_oe && !w_rd_n), 32'd0);
      chk("cs_strobe_same_cycle",
          32'((w_cs_n != prev_cs) && ((w_rd_n != prev_rd) || (w_wr_n != prev_wr))), 32'd0);
      if (data_rdy_ctrl) begin
        chk("rd_q_nonempty", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) chk("read_byte", 32'(data_w2f), 32'(exp_rd.pop_front()));
        rdy_pulses <= rdy_pulses + 1;
      end
      if (!writing_finished_signal) wf_pulses <= wf_pulses + 1;
      prev_cs <= w_cs_n;
      prev_rd <= w_rd_n;
      prev_wr <= w_wr_n;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_rdy, base_wf, n, k, got, write_done;
    logic [11:0] rd_pat, rdy_pat, busy_pat;
    logic [8:0]  cs2_pat, wr2_pat, wf2_pat, busy2_pat;
    logic [7:0]  hi, lo;
    logic        busy_ok, oe_ok;

    rst = 1'b1; start_ctrl = 0; address_in = '0; operation = 0; data_f2w = '0;
    start2 = 0; addr2 = '0; op2 = 0; dout2 = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i ^ 10'h0C3);
    mem[10'h200] = 8'hA5; mem[10'h155] = 8'h5A;
    mem[10'h000] = 8'h12; mem[10'h001] = 8'h34;

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_ctrl), 32'd0);
    chk("rst_rdy", 32'(data_rdy_ctrl), 32'd0);
    chk("rst_wfin", 32'(writing_finished_signal), 32'd1);
    chk("rst_w2f", 32'(data_w2f), 32'd0);
    chk("rst_addr", 32'(w_addr), 32'd0);
    chk("rst_pins", 32'({w_cs_n, w_rd_n, w_wr_n, w_data_oe}), 32'b1110);
    chk("rst_dout", 32'(w_data_out), 32'd0);
    rst = 1'b0;

    // ---- reset mid-STROBE of a write
    @(posedge clk); #1;
    start_ctrl = 1; address_in = 10'h3AA; operation = 0; data_f2w = 8'h77;
    exp_addr.push_back(10'h3AA); exp_wdata.push_back(8'h77);
    @(posedge clk); #1; start_ctrl = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_strobe", 32'({w_wr_n, w_cs_n}), 32'b00);
    rst = 1'b1; #1;
    chk("abort_pins", 32'({w_wr_n, w_cs_n, w_data_oe}), 32'b110);
    chk("abort_busy_wfin", 32'({busy_ctrl, writing_finished_signal}), 32'b01);
    @(negedge clk); rst = 1'b0; #1;
    base_rdy = rdy_pulses; base_wf = wf_pulses;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_pulses", 32'((rdy_pulses - base_rdy) + (wf_pulses - base_wf)), 32'd0);

    // ---- single read with default timing, GAP release, then a fresh read
    @(posedge clk); #1;
    start_ctrl = 1; address_in = 10'h200; operation = 1;
    exp_addr.push_back(10'h200); exp_rd.push_back(8'hA5);
    base_rdy = rdy_pulses;
    @(posedge clk); #1; start_ctrl = 0;
    rd_pat = '0; rdy_pat = '0; busy_pat = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rd_pat[c-1] = ~w_rd_n; rdy_pat[c-1] = data_rdy_ctrl; busy_pat[c-1] = busy_ctrl;
      if (c == 8) begin
        chk("gap_release_cs", 32'(w_cs_n), 32'd1);
        start_ctrl = 1; address_in = 10'h155; operation = 1;
        exp_addr.push_back(10'h155); exp_rd.push_back(8'h5A);
      end
      if (c == 9) begin
        start_ctrl = 0;
        chk("reaccept_cs", 32'(w_cs_n), 32'd0);
      end
    end
    chk("read_rd_low_cycles", 32'(rd_pat[7:0]), 32'b0000_1110);
    chk("read_rdy_cycle", 32'(rdy_pat[7:0]), 32'b0010_0000);
    chk("read_busy_cycles", 32'(busy_pat[8:0]), 32'b1_0111_1111);
    repeat (6) @(negedge clk);
    #1;
    chk("read_two_pulses", 32'(rdy_pulses - base_rdy), 32'd2);
    chk("read_w2f_held", 32'(data_w2f), 32'h5A);

    // ---- chained 16-bit read of register 0x000 (requester model)
    @(posedge clk); #1;
    exp_addr.push_back(10'h000); exp_addr.push_back(10'h001);
    exp_rd.push_back(8'h12); exp_rd.push_back(8'h34);
    base_rdy = rdy_pulses;
    start_ctrl = 1; address_in = 10'h000; operation = 1;
    @(posedge clk); #1; start_ctrl = 0;
    busy_ok = 1; got = 0; n = 0; k = 0; hi = '0; lo = '0;
    while (got < 2 && n < 40) begin
      @(negedge clk); n++;
      if (!busy_ctrl) busy_ok = 0;
      if (got == 1 && n == k + 2) start_ctrl = 0;
      if (data_rdy_ctrl) begin
        if (got == 0) begin
          hi = data_w2f; k = n;
          start_ctrl = 1; address_in = 10'h001; operation = 1;
        end else lo = data_w2f;
        got++;
      end
    end
    start_ctrl = 0;
    chk("rd16_completed", 32'(got), 32'd2);
    chk("rd16_reg_value", 32'({hi, lo}), 32'h1234);
    chk("rd16_busy_continuous", 32'(busy_ok), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("rd16_two_pulses", 32'(rdy_pulses - base_rdy), 32'd2);

    // ---- chained 16-bit write of 0xBEEF to 0x020
    @(posedge clk); #1;
    exp_addr.push_back(10'h020); exp_addr.push_back(10'h021);
    exp_wdata.push_back(8'hBE); exp_wdata.push_back(8'hEF);
    base_wf = wf_pulses; write_done = 0;
    start_ctrl = 1; address_in = 10'h020; operation = 0; data_f2w = 8'hBE;
    @(posedge clk); #1; start_ctrl = 0;
    busy_ok = 1; oe_ok = 1; got = 0; n = 0; k = 0;
    while (got < 2 && n < 40) begin
      @(negedge clk); n++;
      if (!busy_ctrl) busy_ok = 0;
      if (w_data_oe !== ~w_cs_n) oe_ok = 0;
      if (got == 1 && n == k + 2) start_ctrl = 0;
      if (!writing_finished_signal) begin
        if (got == 0) begin
          k = n;
          start_ctrl = 1; address_in = 10'h021; operation = 0; data_f2w = 8'hEF;
        end else write_done++;
        got++;
      end
    end
    start_ctrl = 0;
    chk("wr16_completed", 32'(got), 32'd2);
    chk("wr16_busy_continuous", 32'(busy_ok), 32'd1);
    chk("wr16_oe_window", 32'(oe_ok), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("wr16_two_wfin", 32'(wf_pulses - base_wf), 32'd2);
    chk("wr16_write_done_once", 32'(write_done), 32'd1);
    chk("wr16_idle_after", 32'({busy_ctrl, w_data_oe}), 32'b00);

    // ---- timing parameters T_SETUP=2, T_STROBE=1, T_HOLD=3
    @(posedge clk); #1;
    start2 = 1; addr2 = 10'h0F0; op2 = 0; dout2 = 8'h3C;
    @(posedge clk); #1; start2 = 0;
    cs2_pat = '0; wr2_pat = '0; wf2_pat = '0; busy2_pat = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      cs2_pat[c-1] = ~cs_n2; wr2_pat[c-1] = ~wr_n2; wf2_pat[c-1] = ~wfin2; busy2_pat[c-1] = busy2;
      if (c == 3) chk("p2_strobe_pins", 32'({w_addr2, wdo2, oe2, rd_n2}), 32'({10'h0F0, 8'h3C, 1'b1, 1'b1}));
    end
    chk("p2_cs_low_cycles", 32'(cs2_pat), 32'b0_0011_1111);
    chk("p2_wr_low_cycle", 32'(wr2_pat), 32'b0_0000_0100);
    chk("p2_done_cycle", 32'(wf2_pat), 32'b0_0100_0000);
    chk("p2_busy_cycles", 32'(busy2_pat), 32'b0_1111_1111);

`ifdef W5300_SRAM_ACC_CNT_EN
    // since the mid-write reset: reads 0x200, 0x155, 0x000, 0x001; writes 0x020, 0x021
    chk("cnt_rd", 32'(rd_cnt), 32'd4);
    chk("cnt_wr", 32'(wr_cnt), 32'd2);
    chk("cnt2_wr", 32'({rd_cnt2, wr_cnt2}), 32'h0000_0001);
`endif

    chk("scoreboard_drained", 32'(exp_addr.size() + exp_wdata.size() + exp_rd.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
